ssd_scanner: RTL

Time-multiplexed display scanner for a bank of common-anode seven-segment digits. It latches a packed multi-digit hex value and steps through the digits at a fixed refresh rate. Each step drives one 4-bit nibble into the downstream hex-to-seven-segment decoder, together with the matching active-low anode select. Value updates are committed only at frame boundaries, so a frame never mixes old and new digits.

---
 rtl/ssd_pkg.sv | 18 +
 rtl/ssd_tick_gen.sv | 26 ++
 rtl/ssd_scanner.sv | 110 +++++++++++
 3 files changed

// File: rtl/ssd_pkg.sv
// Shared definitions for the seven-segment scanner: default digit count,
// anode-off pattern and packed-value nibble extraction.
package ssd_pkg;

    localparam int SSD_DIGITS = 4;
    localparam int MAX_DIGITS = 32;
    localparam int VAL_W      = 4 * MAX_DIGITS;

    localparam logic [MAX_DIGITS-1:0] ANODE_OFF = '1;

    function automatic logic [3:0] nib_of(
        input logic [VAL_W-1:0] v,
        input int               i
    );
        return 4'(v >> (4 * i));
    endfunction

endpackage

// File: rtl/ssd_tick_gen.sv
// Digit-slot prescaler: counts 0..PRESCALE-1 and flags the last cycle
// of each slot.
module ssd_tick_gen #(
    parameter int PRESCALE = 50000
) (
    input  logic                        clk,
    input  logic                        rst_n,
    output logic [$clog2(PRESCALE)-1:0] cnt,
    output logic                        slot_end
);

    localparam int CW = $clog2(PRESCALE);

    assign slot_end = (cnt == CW'(PRESCALE - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (slot_end) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + CW'(1);
        end
    end

endmodule

// File: rtl/ssd_scanner.sv
// Time-multiplexed common-anode seven-segment scanner with frame-aligned
// value commits and optional leading-zero blanking.
module ssd_scanner
    import ssd_pkg::*;
#(
    parameter int DIGITS   = SSD_DIGITS,
    parameter int PRESCALE = 50000,
    parameter int DEAD     = 0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  load,
    input  logic [4*DIGITS-1:0]   value,
    input  logic                  blank_lz,
    output logic [3:0]            nibble,
    output logic [DIGITS-1:0]     anode_n,
    output logic                  blank,
    output logic                  frame_done
);

    localparam int IW = $clog2(DIGITS);
    localparam int CW = $clog2(PRESCALE);

    logic [CW-1:0]       cnt;
    logic                slot_end;
    logic [IW-1:0]       idx;
    logic [4*DIGITS-1:0] disp;
    logic [4*DIGITS-1:0] pend;
    logic                pend_v;
    logic                boundary;
    logic                dead;
    logic                zero_run;
    logic [DIGITS-1:0]   lz;
    logic [3:0]          nib_d;
    logic [DIGITS-1:0]   an_d;
    logic                blank_d;

    ssd_tick_gen #(
        .PRESCALE (PRESCALE)
    ) u_tick (
        .clk      (clk),
        .rst_n    (rst_n),
        .cnt      (cnt),
        .slot_end (slot_end)
    );

    assign boundary = slot_end && (idx == IW'(DIGITS - 1));
    // Signed compare keeps DEAD=0 a plain always-false test.
    assign dead     = (int'(cnt) < DEAD);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx <= '0;
        end else if (slot_end) begin
            idx <= boundary ? '0 : idx + IW'(1);
        end
    end

    // A load on the boundary itself bypasses the pending register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            disp   <= '0;
            pend   <= '0;
            pend_v <= 1'b0;
        end else if (boundary) begin
            if (load) begin
                disp <= value;
            end else if (pend_v) begin
                disp <= pend;
            end
            pend_v <= 1'b0;
        end else if (load) begin
            pend   <= value;
            pend_v <= 1'b1;
        end
    end

    always_comb begin
        lz       = '0;
        zero_run = 1'b1;
        for (int i = DIGITS - 1; i > 0; i--) begin
            zero_run = zero_run && (nib_of(VAL_W'(disp), i) == 4'h0);
            lz[i]    = blank_lz && zero_run;
        end
    end

    always_comb begin
        nib_d = nib_of(VAL_W'(disp), int'(idx));
        an_d  = ANODE_OFF[DIGITS-1:0];
        if (!dead) begin
            an_d[idx] = 1'b0;
        end
        blank_d = dead || lz[idx];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            nibble     <= 4'h0;
            anode_n    <= ANODE_OFF[DIGITS-1:0];
            blank      <= 1'b1;
            frame_done <= 1'b0;
        end else begin
            nibble     <= nib_d;
            anode_n    <= an_d;
            blank      <= blank_d;
            frame_done <= boundary;
        end
    end

endmodule
